// File: rtl/edf_queue_scheduler.sv
// Earliest-deadline-first arbiter: picks the non-empty queue with the least remaining countdown and
// presents its head two cycles after it is seen; the selected entry is held in ISSUE until out_ready.
module edf_queue_scheduler #(
    parameter int NUM_QUEUES    = 4,
    parameter int DATA_SIZE     = 8,
    parameter int REGISTER_SIZE = 32,
    localparam int ID_W         = $clog2(NUM_QUEUES)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [NUM_QUEUES*REGISTER_SIZE-1:0] period,
    input  logic [NUM_QUEUES-1:0]               queue_empty,
    input  logic [NUM_QUEUES*DATA_SIZE-1:0]     queue_data,
    output logic [NUM_QUEUES-1:0]               queue_consumed,
    output logic [DATA_SIZE-1:0]                out_data,
    output logic [ID_W-1:0]                     out_queue_id,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_QUEUES-1:0]               deadline_miss
);

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE} state_t;

    state_t                   state_q, state_d;
    logic [REGISTER_SIZE-1:0] countdown_q [NUM_QUEUES];
    logic [REGISTER_SIZE-1:0] countdown_d [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]    miss_q, miss_d;
    logic [DATA_SIZE-1:0]     data_q, data_d;
    logic [ID_W-1:0]          id_q, id_d;

    logic [REGISTER_SIZE-1:0] per_w  [NUM_QUEUES];
    logic [REGISTER_SIZE-1:0] key_w  [NUM_QUEUES];
    logic [DATA_SIZE-1:0]     head_w [NUM_QUEUES];
    logic                     hs;
    logic                     win_vld;
    logic [ID_W-1:0]          win_id;
    logic [REGISTER_SIZE-1:0] win_key;

    // Best-effort queues (period 0) compete with an all-ones key so they lose to any finite deadline.
    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            per_w[i]  = period[i*REGISTER_SIZE +: REGISTER_SIZE];
            head_w[i] = queue_data[i*DATA_SIZE +: DATA_SIZE];
            key_w[i]  = (per_w[i] != '0) ? countdown_q[i] : '1;
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        win_key = '1;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (!queue_empty[i] && (!win_vld || key_w[i] < win_key)) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
                win_key = key_w[i];
            end
        end
    end

    assign hs = (state_q == ISSUE) && out_ready && !reset;

    always_comb begin
        queue_consumed = '0;
        if (hs) begin
            queue_consumed[id_q] = 1'b1;
        end
    end

    always_comb begin
        miss_d = miss_q;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (queue_empty[i] || per_w[i] == '0 || (hs && id_q == ID_W'(i))) begin
                countdown_d[i] = per_w[i];
            end else if (countdown_q[i] != '0) begin
                countdown_d[i] = countdown_q[i] - 1'b1;
            end else begin
                countdown_d[i] = '0;
            end
            if (!queue_empty[i] && per_w[i] != '0 && countdown_q[i] == '0) begin
                miss_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (enable && |(~queue_empty)) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                // A queue drained between IDLE and SELECT leaves nothing to issue.
                if (win_vld) begin
                    id_d    = win_id;
                    data_d  = head_w[win_id];
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            data_q  <= '0;
            miss_q  <= '0;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                countdown_q[i] <= per_w[i];
            end
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            data_q  <= data_d;
            miss_q  <= miss_d;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                countdown_q[i] <= countdown_d[i];
            end
        end
    end

    assign out_valid     = (state_q == ISSUE);
    assign out_data      = data_q;
    assign out_queue_id  = id_q;
    assign deadline_miss = miss_q;

endmodule

// File: tb/tb_edf_queue_scheduler.sv
// Directed bench for edf_queue_scheduler: a small queue model feeds the DUT and a scoreboard
// holds the expected grant order, checked on every handshake.
module tb_edf_queue_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [127:0] period;
    logic [3:0]   queue_empty;
    logic [31:0]  queue_data;
    logic [3:0]   queue_consumed;
    logic [7:0]   out_data;
    logic [1:0]   out_queue_id;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   deadline_miss;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb [$];
    int   cnt    [4] = '{default: 0};
    int   ld_cnt [4] = '{default: 0};
    logic [3:0] ld;
    int   n_tests = 0;
    int   n_fail  = 0;

    edf_queue_scheduler #(.NUM_QUEUES(4), .DATA_SIZE(8), .REGISTER_SIZE(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .period         (period),
        .queue_empty    (queue_empty),
        .queue_data     (queue_data),
        .queue_consumed (queue_consumed),
        .out_data       (out_data),
        .out_queue_id   (out_queue_id),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .deadline_miss  (deadline_miss)
    );

    always #5 clock = ~clock;

    // Queue model: head of queue i is 16*i + remaining entry count.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (ld[i]) cnt[i] <= ld_cnt[i];
            else if (queue_consumed[i]) cnt[i] <= cnt[i] - 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            queue_empty[i]          = (cnt[i] == 0);
            queue_data[i*8 +: 8]    = 8'(i * 16 + cnt[i]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                chk("consumed_onehot", 64'(queue_consumed), 64'(4'b1 << out_queue_id));
                chk("grant_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("grant_id", 64'(out_queue_id), 64'(e.id));
                    chk("grant_data", 64'(out_data), 64'(e.data));
                end
            end else begin
                chk("consumed_idle", 64'(queue_consumed), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_period(input int p0, input int p1, input int p2, input int p3);
        period = {32'(p3), 32'(p2), 32'(p1), 32'(p0)};
    endtask

    task automatic load(input int q, input int n);
        ld_cnt[q] = n;
        ld[q]     = 1'b1;
    endtask

    task automatic expect_grant(input int q, input int d);
        exp_t e;
        e.id   = 2'(q);
        e.data = 8'(d);
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0; period = '0; ld = '0;
        repeat (3) tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_id", 64'(out_queue_id), 64'd0);
        chk("rst_miss", 64'(deadline_miss), 64'd0);
        chk("rst_consumed", 64'(queue_consumed), 64'd0);

        // Single queue: out_valid two cycles after the queue is seen non-empty.
        reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
        set_period(10, 0, 0, 0);
        tick();
        load(0, 1); expect_grant(0, 8'h01);
        tick(); ld = '0;
        tick(); chk("lat_t1_valid", 64'(out_valid), 64'd0);
        tick(); chk("lat_t2_valid", 64'(out_valid), 64'd1);
        chk("lat_id", 64'(out_queue_id), 64'd0);
        chk("lat_data", 64'(out_data), 64'h01);
        tick(); chk("post_hs_valid", 64'(out_valid), 64'd0);
        chk("q0_popped", 64'(cnt[0]), 64'd0);

        // Mixed deadlines plus one best-effort queue.
        set_period(20, 5, 40, 0);
        for (int i = 0; i < 4; i++) load(i, 1);
        expect_grant(1, 8'h11); expect_grant(0, 8'h01);
        expect_grant(2, 8'h21); expect_grant(3, 8'h31);
        tick(); ld = '0;
        drain("edf_drain", 60);
        chk("edf_miss", 64'(deadline_miss), 64'd0);

        // Equal periods: lowest index first; late queues 2 and 3 run out of time.
        set_period(8, 8, 8, 8);
        for (int i = 0; i < 4; i++) load(i, 1);
        for (int i = 0; i < 4; i++) expect_grant(i, i * 16 + 1);
        tick(); ld = '0;
        tick(); tick();
        chk("tie_valid", 64'(out_valid), 64'd1);
        chk("tie_first_id", 64'(out_queue_id), 64'd0);
        drain("tie_drain", 60);
        chk("tie_miss", 64'(deadline_miss), 64'hC);

        reset = 1'b1;
        tick(); tick();
        chk("reset_clears_miss", 64'(deadline_miss), 64'd0);
        reset = 1'b0;

        // Backpressure: outputs held, miss flag registers once countdown reaches 0.
        set_period(0, 0, 3, 0);
        out_ready = 1'b0;
        load(2, 1); expect_grant(2, 8'h21);
        tick(); ld = '0;
        tick(); tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_id", 64'(out_queue_id), 64'd2);
        chk("bp_data", 64'(out_data), 64'h21);
        for (int k = 4; k <= 12; k++) begin
            tick();
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", 64'(out_data), 64'h21);
            chk("bp_hold_consumed", 64'(queue_consumed), 64'd0);
            chk("bp_miss", 64'(deadline_miss), (k >= 5) ? 64'h4 : 64'h0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_popped", 64'(cnt[2]), 64'd0);

        // enable low: no selection; dropping enable in ISSUE still completes the transfer.
        enable = 1'b0;
        set_period(10, 0, 0, 0);
        load(0, 2);
        tick(); ld = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("en_low_valid", 64'(out_valid), 64'd0);
        end
        enable = 1'b1; out_ready = 1'b0;
        expect_grant(0, 8'h02);
        tick(); tick();
        chk("en_issue_valid", 64'(out_valid), 64'd1);
        enable = 1'b0; out_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_reselect_valid", 64'(out_valid), 64'd0);
        end
        chk("en_popped_once", 64'(cnt[0]), 64'd1);
        chk("en_sb_empty", 64'(sb.size()), 64'd0);

        // Reset during ISSUE: the pending entry must survive.
        enable = 1'b1; out_ready = 1'b0;
        tick(); tick();
        chk("rst_issue_valid", 64'(out_valid), 64'd1);
        reset = 1'b1; out_ready = 1'b1;
        tick();
        chk("rst_issue_valid_low", 64'(out_valid), 64'd0);
        chk("rst_issue_consumed", 64'(queue_consumed), 64'd0);
        chk("rst_issue_miss", 64'(deadline_miss), 64'd0);
        chk("rst_issue_data", 64'(out_data), 64'd0);
        chk("rst_not_consumed", 64'(cnt[0]), 64'd1);
        reset = 1'b0;
        expect_grant(0, 8'h01);
        drain("post_rst_drain", 20);
        tick();
        chk("post_rst_popped", 64'(cnt[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
